// File: rtl/bp_me_dma_bank_arbiter_pkg.sv
// bp_me_dma_bank_arbiter_pkg: shared DMA packet struct macro and packet FSM states
`define DECLARE_BP_ME_DMA_PKT_S(addr_width) \
  typedef struct packed { \
    logic write_not_read; \
    logic [addr_width-1:0] addr; \
  } bp_me_dma_pkt_s

package bp_me_dma_bank_arbiter_pkg;
  typedef enum logic {e_idle, e_wdata} state_e;
endpackage

// File: rtl/bp_me_dma_bank_arbiter_fifo.sv
// bp_me_dma_bank_arbiter_fifo: small 1r1w FIFO recording the bank order of issued reads
module bp_me_dma_bank_arbiter_fifo #(
  parameter int width_p = 1,
  parameter int els_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);
  localparam int ptr_w = els_p > 1 ? $clog2(els_p) : 1;
  localparam int cnt_w = $clog2(els_p + 1);
  logic [width_p-1:0] mem [els_p];
  logic [ptr_w-1:0] wptr, rptr;
  logic [cnt_w-1:0] count;
  logic push, pop;
  assign ready_o = count != cnt_w'(els_p);
  assign v_o = count != '0;
  assign data_o = mem[rptr];
  assign push = v_i & ready_o;
  assign pop = yumi_i & v_o;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= (wptr == ptr_w'(els_p - 1)) ? '0 : wptr + 1'b1;
      if (pop) rptr <= (rptr == ptr_w'(els_p - 1)) ? '0 : rptr + 1'b1;
      count <= count + cnt_w'(push) - cnt_w'(pop);
    end
  always_ff @(posedge clk_i)
    if (push) mem[wptr] <= data_i;
endmodule

// File: rtl/bp_me_dma_bank_arbiter.sv
// bp_me_dma_bank_arbiter: round-robin sharing of one DMA channel among cache banks
module bp_me_dma_bank_arbiter
  import bp_me_dma_bank_arbiter_pkg::*;
#(
  parameter int banks_p = 2,
  parameter int addr_width_p = 28,
  parameter int fill_width_p = 64,
  parameter int block_beats_p = 8,
  parameter int reads_outstanding_p = 4,
  localparam int dma_pkt_width_lp = 1 + addr_width_p
) (
  input  logic                                      clk_i,
  input  logic                                      reset_i,
  input  logic [banks_p-1:0][dma_pkt_width_lp-1:0]  bank_pkt_i,
  input  logic [banks_p-1:0]                        bank_pkt_v_i,
  output logic [banks_p-1:0]                        bank_pkt_ready_and_o,
  output logic [banks_p-1:0][fill_width_p-1:0]      bank_data_o,
  output logic [banks_p-1:0]                        bank_data_v_o,
  input  logic [banks_p-1:0]                        bank_data_ready_and_i,
  input  logic [banks_p-1:0][fill_width_p-1:0]      bank_data_i,
  input  logic [banks_p-1:0]                        bank_data_v_i,
  output logic [banks_p-1:0]                        bank_data_ready_and_o,
  output logic [dma_pkt_width_lp-1:0]               dma_pkt_o,
  output logic                                      dma_pkt_v_o,
  input  logic                                      dma_pkt_ready_and_i,
  input  logic [fill_width_p-1:0]                   dma_data_i,
  input  logic                                      dma_data_v_i,
  output logic                                      dma_data_ready_and_o,
  output logic [fill_width_p-1:0]                   dma_data_o,
  output logic                                      dma_data_v_o,
  input  logic                                      dma_data_ready_and_i
);
  localparam int id_w = banks_p > 1 ? $clog2(banks_p) : 1;
  localparam int cnt_w = block_beats_p > 1 ? $clog2(block_beats_p) : 1;
  `DECLARE_BP_ME_DMA_PKT_S(addr_width_p);
  state_e state, state_n;
  bp_me_dma_pkt_s win_pkt;
  logic [id_w-1:0] rr, winner, wbank, rbank, idx;
  logic [cnt_w-1:0] wcnt, rcnt;
  logic found, fifo_ready, fifo_v, accept, push, wbeat, wlast, rbeat, pop;
  always_comb begin
    found = 1'b0;
    winner = rr;
    idx = '0;
    for (int i = 0; i < banks_p; i++) begin
      idx = id_w'((int'(rr) + i) % banks_p);
      if (!found && bank_pkt_v_i[idx] && (bank_pkt_i[idx][dma_pkt_width_lp-1] || fifo_ready)) begin
        found = 1'b1;
        winner = idx;
      end
    end
  end
  // Packet grant only in e_idle; write data is steered from the latched write bank.
  always_comb begin
    win_pkt = bank_pkt_i[winner];
    dma_pkt_o = win_pkt;
    dma_pkt_v_o = !reset_i && state == e_idle && found;
    bank_pkt_ready_and_o = '0;
    if (dma_pkt_v_o) bank_pkt_ready_and_o[winner] = dma_pkt_ready_and_i;
    accept = dma_pkt_v_o && dma_pkt_ready_and_i;
    push = accept && !win_pkt.write_not_read;
    dma_data_o = bank_data_i[wbank];
    dma_data_v_o = !reset_i && state == e_wdata && bank_data_v_i[wbank];
    bank_data_ready_and_o = '0;
    if (!reset_i && state == e_wdata) bank_data_ready_and_o[wbank] = dma_data_ready_and_i;
    wbeat = dma_data_v_o && dma_data_ready_and_i;
    wlast = wbeat && wcnt == cnt_w'(block_beats_p - 1);
    state_n = (accept && win_pkt.write_not_read) ? e_wdata : wlast ? e_idle : state;
    bank_data_v_o = '0;
    if (!reset_i && fifo_v) bank_data_v_o[rbank] = dma_data_v_i;
    dma_data_ready_and_o = !reset_i && fifo_v && bank_data_ready_and_i[rbank];
    rbeat = dma_data_v_i && dma_data_ready_and_o;
    pop = rbeat && rcnt == cnt_w'(block_beats_p - 1);
  end
  assign bank_data_o = {banks_p{dma_data_i}};
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state <= e_idle;
      rr <= '0;
      wbank <= '0;
      wcnt <= '0;
      rcnt <= '0;
    end else begin
      state <= state_n;
      if (accept) rr <= (winner == id_w'(banks_p - 1)) ? '0 : winner + 1'b1;
      if (accept && win_pkt.write_not_read) begin
        wbank <= winner;
        wcnt <= '0;
      end else if (wbeat) wcnt <= wlast ? '0 : wcnt + 1'b1;
      if (rbeat) rcnt <= pop ? '0 : rcnt + 1'b1;
    end
  bp_me_dma_bank_arbiter_fifo #(.width_p(id_w), .els_p(reads_outstanding_p)) order_fifo (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .v_i(push),
    .data_i(winner),
    .ready_o(fifo_ready),
    .v_o(fifo_v),
    .data_o(rbank),
    .yumi_i(pop)
  );
endmodule

// File: tb/tb_bp_me_dma_bank_arbiter.sv
// tb_bp_me_dma_bank_arbiter: directed checks of grant order, write lock, read steering and reset
module tb_bp_me_dma_bank_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0][28:0] bank_pkt;
  logic [1:0] bank_pkt_v, bank_pkt_rdy;
  logic [1:0][63:0] bank_rdata, bank_wdata;
  logic [1:0] bank_rdata_v, bank_rdata_rdy, bank_wdata_v, bank_wdata_rdy;
  logic [28:0] dma_pkt;
  logic dma_pkt_v, dma_pkt_rdy;
  logic [63:0] dma_rdata, dma_wdata;
  logic dma_rdata_v, dma_rdata_rdy, dma_wdata_v, dma_wdata_rdy;
  int n = 0;
  int p = 0;
  always #5 clk = ~clk;
  bp_me_dma_bank_arbiter dut (
    .clk_i(clk), .reset_i(rst),
    .bank_pkt_i(bank_pkt), .bank_pkt_v_i(bank_pkt_v), .bank_pkt_ready_and_o(bank_pkt_rdy),
    .bank_data_o(bank_rdata), .bank_data_v_o(bank_rdata_v), .bank_data_ready_and_i(bank_rdata_rdy),
    .bank_data_i(bank_wdata), .bank_data_v_i(bank_wdata_v), .bank_data_ready_and_o(bank_wdata_rdy),
    .dma_pkt_o(dma_pkt), .dma_pkt_v_o(dma_pkt_v), .dma_pkt_ready_and_i(dma_pkt_rdy),
    .dma_data_i(dma_rdata), .dma_data_v_i(dma_rdata_v), .dma_data_ready_and_o(dma_rdata_rdy),
    .dma_data_o(dma_wdata), .dma_data_v_o(dma_wdata_v), .dma_data_ready_and_i(dma_wdata_rdy)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs();
    bank_pkt = '0; bank_pkt_v = '0; bank_rdata_rdy = '0; bank_wdata = '0; bank_wdata_v = '0;
    dma_pkt_rdy = 1'b1; dma_rdata = '0; dma_rdata_v = 1'b0; dma_wdata_rdy = 1'b1;
  endtask
  task automatic test_reset();
    idle_inputs();
    bank_pkt_v = 2'b11; bank_wdata_v = 2'b11; dma_rdata_v = 1'b1; bank_rdata_rdy = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    n++; if (dma_pkt_v !== 1'b0) $display("FAIL rst_pkt_v got %0b want 0", dma_pkt_v); else p++;
    n++; if (bank_pkt_rdy !== 2'b00) $display("FAIL rst_pkt_rdy got %b want 00", bank_pkt_rdy); else p++;
    n++; if (bank_rdata_v !== 2'b00) $display("FAIL rst_rdata_v got %b want 00", bank_rdata_v); else p++;
    n++; if (dma_rdata_rdy !== 1'b0) $display("FAIL rst_rdata_rdy got %b want 0", dma_rdata_rdy); else p++;
    n++; if (dma_wdata_v !== 1'b0 || bank_wdata_rdy !== 2'b00) $display("FAIL rst_wdata got v=%b rdy=%b want 0/00", dma_wdata_v, bank_wdata_rdy); else p++;
    idle_inputs();
    rst = 1'b0;
    #1;
    n++; if (dma_pkt_v !== 1'b0) $display("FAIL post_rst_pkt_v got %0b want 0", dma_pkt_v); else p++;
    step();
  endtask
  task automatic test_reads_rr();
    int to0 = 0;
    int to1 = 0;
    bank_pkt[0] = {1'b0, 28'h100}; bank_pkt[1] = {1'b0, 28'h200}; bank_pkt_v = 2'b11;
    #1;
    n++; if (dma_pkt !== {1'b0, 28'h100} || bank_pkt_rdy !== 2'b01) $display("FAIL rr_first got pkt=%h rdy=%b want 0100/01", dma_pkt, bank_pkt_rdy); else p++;
    step();
    #1;
    n++; if (dma_pkt !== {1'b0, 28'h200} || bank_pkt_rdy !== 2'b10) $display("FAIL rr_second got pkt=%h rdy=%b want 0200/10", dma_pkt, bank_pkt_rdy); else p++;
    step();
    bank_pkt_v = 2'b00; bank_rdata_rdy = 2'b11; dma_rdata_v = 1'b1;
    for (int k = 0; k < 16; k++) begin
      dma_rdata = 64'hD000 + 64'(k);
      #1;
      n++; if (bank_rdata_v !== (k < 8 ? 2'b01 : 2'b10) || dma_rdata_rdy !== 1'b1) $display("FAIL rd_beat%0d got v=%b rdy=%b want %b/1", k, bank_rdata_v, dma_rdata_rdy, (k < 8 ? 2'b01 : 2'b10)); else p++;
      n++; if (bank_rdata[1] !== 64'hD000 + 64'(k)) $display("FAIL rd_data%0d got %h want %h", k, bank_rdata[1], 64'hD000 + 64'(k)); else p++;
      if (bank_rdata_v[0] && dma_rdata_rdy) to0++;
      if (bank_rdata_v[1] && dma_rdata_rdy) to1++;
      step();
    end
    n++; if (to0 !== 8 || to1 !== 8) $display("FAIL rd_split got %0d/%0d want 8/8", to0, to1); else p++;
    #1;
    n++; if (dma_rdata_rdy !== 1'b0) $display("FAIL rd_drained_rdy got %b want 0", dma_rdata_rdy); else p++;
    dma_rdata_v = 1'b0;
  endtask
  task automatic test_empty_fifo();
    dma_rdata_v = 1'b1; bank_rdata_rdy = 2'b11; dma_rdata = 64'hBAD;
    for (int k = 0; k < 10; k++) begin
      #1;
      n++; if (dma_rdata_rdy !== 1'b0 || bank_rdata_v !== 2'b00) $display("FAIL empty%0d got rdy=%b v=%b want 0/00", k, dma_rdata_rdy, bank_rdata_v); else p++;
      step();
    end
    dma_rdata_v = 1'b0;
  endtask
  task automatic test_write_concurrent();
    int got = 0;
    bank_pkt[0] = {1'b0, 28'h300}; bank_pkt_v = 2'b01;
    #1;
    n++; if (bank_pkt_rdy !== 2'b01) $display("FAIL wc_rd_pre got %b want 01", bank_pkt_rdy); else p++;
    step();
    bank_pkt[0] = {1'b0, 28'h400}; bank_pkt[1] = {1'b1, 28'h40}; bank_pkt_v = 2'b11;
    #1;
    n++; if (dma_pkt !== {1'b1, 28'h40} || bank_pkt_rdy !== 2'b10) $display("FAIL wc_grant got pkt=%h rdy=%b want 10000040/10", dma_pkt, bank_pkt_rdy); else p++;
    step();
    bank_pkt_v = 2'b01; bank_wdata_v = 2'b10; dma_rdata_v = 1'b1;
    for (int c = 0; c < 8; c++) begin
      bank_wdata[1] = 64'hA0 + 64'(c);
      bank_rdata_rdy = {1'b0, (c % 2) == 0};
      #1;
      n++; if (dma_pkt_v !== 1'b0 || bank_pkt_rdy !== 2'b00) $display("FAIL wc_lock%0d got v=%b rdy=%b want 0/00", c, dma_pkt_v, bank_pkt_rdy); else p++;
      n++; if (dma_wdata_v !== 1'b1 || dma_wdata !== 64'hA0 + 64'(c) || bank_wdata_rdy !== 2'b10) $display("FAIL wc_wbeat%0d got v=%b d=%h rdy=%b want 1/%h/10", c, dma_wdata_v, dma_wdata, bank_wdata_rdy, 64'hA0 + 64'(c)); else p++;
      n++; if (bank_rdata_v !== 2'b01 || dma_rdata_rdy !== ((c % 2) == 0)) $display("FAIL wc_rbeat%0d got v=%b rdy=%b want 01/%0d", c, bank_rdata_v, dma_rdata_rdy, (c % 2) == 0); else p++;
      if (bank_rdata_v[0] && dma_rdata_rdy) got++;
      step();
    end
    n++; if (got !== 4) $display("FAIL wc_rd_during_w got %0d want 4", got); else p++;
    bank_wdata_v = 2'b00; dma_rdata_v = 1'b0;
    bank_pkt[0] = {1'b0, 28'h400}; bank_pkt[1] = {1'b0, 28'h500}; bank_pkt_v = 2'b11;
    #1;
    n++; if (dma_wdata_v !== 1'b0 || dma_pkt !== {1'b0, 28'h400} || bank_pkt_rdy !== 2'b01) $display("FAIL wc_after_w got wv=%b pkt=%h rdy=%b want 0/0400/01", dma_wdata_v, dma_pkt, bank_pkt_rdy); else p++;
    step();
    #1;
    n++; if (dma_pkt !== {1'b0, 28'h500} || bank_pkt_rdy !== 2'b10) $display("FAIL wc_next got pkt=%h rdy=%b want 0500/10", dma_pkt, bank_pkt_rdy); else p++;
    step();
    bank_pkt_v = 2'b00; bank_rdata_rdy = 2'b11; dma_rdata_v = 1'b1;
    for (int k = 0; k < 20; k++) begin
      #1;
      n++; if (bank_rdata_v !== (k < 12 ? 2'b01 : 2'b10)) $display("FAIL wc_drain%0d got %b want %b", k, bank_rdata_v, (k < 12 ? 2'b01 : 2'b10)); else p++;
      step();
    end
    dma_rdata_v = 1'b0;
    #1;
    n++; if (dma_rdata_rdy !== 1'b0) $display("FAIL wc_empty got %b want 0", dma_rdata_rdy); else p++;
  endtask
  task automatic test_fifo_full();
    bank_pkt_v = 2'b10;
    for (int k = 0; k < 4; k++) begin
      bank_pkt[1] = {1'b0, 28'h600 + 28'(k)};
      #1;
      n++; if (bank_pkt_rdy !== 2'b10) $display("FAIL ff_fill%0d got %b want 10", k, bank_pkt_rdy); else p++;
      step();
    end
    bank_pkt[0] = {1'b0, 28'h700}; bank_pkt_v = 2'b01;
    #1;
    n++; if (dma_pkt_v !== 1'b0) $display("FAIL ff_rd_blocked got %b want 0", dma_pkt_v); else p++;
    bank_pkt[1] = {1'b1, 28'h80}; bank_pkt_v = 2'b11;
    #1;
    n++; if (dma_pkt !== {1'b1, 28'h80} || bank_pkt_rdy !== 2'b10) $display("FAIL ff_wr_grant got pkt=%h rdy=%b want 10000080/10", dma_pkt, bank_pkt_rdy); else p++;
    step();
    bank_pkt_v = 2'b01; bank_wdata_v = 2'b10;
    for (int c = 0; c < 8; c++) begin
      #1;
      n++; if (dma_pkt_v !== 1'b0 || dma_wdata_v !== 1'b1) $display("FAIL ff_w%0d got pv=%b wv=%b want 0/1", c, dma_pkt_v, dma_wdata_v); else p++;
      step();
    end
    bank_wdata_v = 2'b00; bank_rdata_rdy = 2'b11; dma_rdata_v = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      n++; if (dma_pkt_v !== 1'b0 || bank_rdata_v !== 2'b10) $display("FAIL ff_ret%0d got pv=%b rv=%b want 0/10", k, dma_pkt_v, bank_rdata_v); else p++;
      step();
    end
    dma_rdata_v = 1'b0;
    #1;
    n++; if (dma_pkt !== {1'b0, 28'h700} || bank_pkt_rdy !== 2'b01) $display("FAIL ff_rd_resume got pkt=%h rdy=%b want 0700/01", dma_pkt, bank_pkt_rdy); else p++;
    step();
    bank_pkt_v = 2'b00;
  endtask
  task automatic test_reset_mid_write();
    bank_pkt[1] = {1'b1, 28'h90}; bank_pkt_v = 2'b10;
    #1;
    n++; if (bank_pkt_rdy !== 2'b10) $display("FAIL rm_grant got %b want 10", bank_pkt_rdy); else p++;
    step();
    bank_pkt_v = 2'b00; bank_wdata_v = 2'b10;
    repeat (3) step();
    bank_pkt[0] = {1'b0, 28'hA00}; bank_pkt_v = 2'b01; dma_rdata_v = 1'b1; bank_rdata_rdy = 2'b11;
    #1;
    n++; if (dma_wdata_v !== 1'b1 || dma_rdata_rdy !== 1'b1) $display("FAIL rm_pre got wv=%b rrdy=%b want 1/1", dma_wdata_v, dma_rdata_rdy); else p++;
    rst = 1'b1;
    #1;
    n++; if (dma_wdata_v !== 1'b0 || bank_wdata_rdy !== 2'b00) $display("FAIL rm_wdrop got v=%b rdy=%b want 0/00", dma_wdata_v, bank_wdata_rdy); else p++;
    n++; if (dma_rdata_rdy !== 1'b0 || bank_rdata_v !== 2'b00) $display("FAIL rm_rdrop got rdy=%b v=%b want 0/00", dma_rdata_rdy, bank_rdata_v); else p++;
    n++; if (dma_pkt_v !== 1'b0 || bank_pkt_rdy !== 2'b00) $display("FAIL rm_pdrop got v=%b rdy=%b want 0/00", dma_pkt_v, bank_pkt_rdy); else p++;
    step();
    rst = 1'b0;
    #1;
    n++; if (dma_wdata_v !== 1'b0 || bank_wdata_rdy !== 2'b00) $display("FAIL rm_idle got wv=%b rdy=%b want 0/00", dma_wdata_v, bank_wdata_rdy); else p++;
    n++; if (dma_rdata_rdy !== 1'b0 || bank_rdata_v !== 2'b00) $display("FAIL rm_empty got rdy=%b v=%b want 0/00", dma_rdata_rdy, bank_rdata_v); else p++;
    n++; if (dma_pkt !== {1'b0, 28'hA00} || bank_pkt_rdy !== 2'b01) $display("FAIL rm_regrant got pkt=%h rdy=%b want 0A00/01", dma_pkt, bank_pkt_rdy); else p++;
    idle_inputs();
  endtask
  initial begin
    test_reset();
    test_reads_rr();
    test_empty_fifo();
    test_write_concurrent();
    test_fifo_full();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", p, n);
    $finish;
  end
endmodule
